td_init_ctrl: RTL and testbench

Bring-up and supervision controller for the TV-decoder video input path.
- Holds the decoder in reset, then loads a fixed 8-entry register table through an external I2C write master using a req/ack handshake.
- Waits for the TD detector's stable indication, then enables the downstream video capture.
- Re-initialises on lock timeout or I2C error. Declares failure after MAX_RETRY attempts.

---
 rtl/td_init_ctrl.sv | 115 +++++++++++
 tb/tb_td_init_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/td_init_ctrl.sv
// td_init_ctrl: TV-decoder bring-up: reset hold, 8-entry I2C table load, lock wait, retry/fail supervision.
// Define TD_RELOCK_EN to fall back from S_RUN to S_LOCK after LOST_CYCLES unstable cycles.
module td_init_ctrl #(
    parameter int RST_HOLD      = 50000,
    parameter int SETTLE        = 100000,
    parameter int STABLE_FILTER = 1000,
    parameter int LOCK_TIMEOUT  = 5000000,
    parameter int LOST_CYCLES   = 2000,
    parameter int MAX_RETRY     = 3
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iTD_Stable,
    input  logic        iNTSC,
    input  logic        iPAL,
    output logic        oTD_RESET_N,
    output logic        oI2C_REQ,
    output logic [23:0] oI2C_DATA,
    input  logic        iI2C_ACK,
    input  logic        iI2C_ERR,
    output logic        oVID_EN,
    output logic [1:0]  oSTD,
    output logic        oBUSY,
    output logic        oFAIL,
    output logic [3:0]  oRETRY
);
`ifdef TD_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif
    localparam int M1   = RST_HOLD > SETTLE ? RST_HOLD : SETTLE;
    localparam int M2   = M1 > LOCK_TIMEOUT ? M1 : LOCK_TIMEOUT;
    localparam int CMAX = M2 > LOST_CYCLES ? M2 : LOST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int FW   = $clog2(STABLE_FILTER + 1);
    localparam logic [23:0] TBL [0:7] = '{
        24'h400F00, 24'h400004, 24'h401741, 24'h403102,
        24'h403DA2, 24'h403E6A, 24'h403FA0, 24'h400E00
    };

    typedef enum logic [2:0] {S_RESET, S_WAKE, S_WRITE, S_LOCK, S_RUN, S_FAIL} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [FW-1:0] filt;
    logic [2:0]    idx;
    logic [3:0]    retry;
    logic          req, retry_go;
    logic [1:0]    stab_q, ntsc_q, pal_q;
    logic          stable_s, ntsc_s, pal_s, wr_done;

    assign stable_s = stab_q[1];
    assign ntsc_s   = ntsc_q[1];
    assign pal_s    = pal_q[1];
    assign wr_done  = req && iI2C_ACK;

    always_comb begin
        nxt      = state;
        retry_go = 1'b0;
        case (state)
            S_RESET: nxt = (cnt == CW'(RST_HOLD - 1)) ? S_WAKE : S_RESET;
            S_WAKE:  nxt = (cnt == CW'(SETTLE - 1)) ? S_WRITE : S_WAKE;
            S_WRITE: begin
                retry_go = wr_done && iI2C_ERR;
                nxt      = (wr_done && !iI2C_ERR && idx == 3'd7) ? S_LOCK : S_WRITE;
            end
            // lock completion takes priority over a coincident timeout
            S_LOCK: begin
                nxt      = (stable_s && filt == FW'(STABLE_FILTER - 1)) ? S_RUN : S_LOCK;
                retry_go = (nxt == S_LOCK) && (cnt == CW'(LOCK_TIMEOUT - 1));
            end
            S_RUN:   nxt = (RELOCK && !stable_s && cnt == CW'(LOST_CYCLES - 1)) ? S_LOCK : S_RUN;
            default: nxt = state;
        endcase
        if (retry_go)
            nxt = (retry < 4'(MAX_RETRY)) ? S_RESET : S_FAIL;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state  <= S_RESET;
            cnt    <= '0;
            filt   <= '0;
            idx    <= '0;
            retry  <= '0;
            req    <= 1'b0;
            stab_q <= '0;
            ntsc_q <= '0;
            pal_q  <= '0;
        end else begin
            state  <= nxt;
            stab_q <= {stab_q[0], iTD_Stable};
            ntsc_q <= {ntsc_q[0], iNTSC};
            pal_q  <= {pal_q[0], iPAL};
            cnt    <= (nxt != state) ? '0 :
                      (state inside {S_RESET, S_WAKE, S_LOCK} || (RELOCK && state == S_RUN && !stable_s)) ?
                      cnt + 1'b1 : '0;
            filt   <= (state == S_LOCK && nxt == S_LOCK && stable_s) ? filt + 1'b1 : '0;
            idx    <= (nxt != S_WRITE) ? '0 : (state == S_WRITE && wr_done) ? idx + 1'b1 : idx;
            // drop for one cycle after each ACK so requests are always separated
            req    <= (state == S_WRITE && nxt == S_WRITE) ? (req ? !iI2C_ACK : 1'b1) : 1'b0;
            retry  <= (retry_go && retry < 4'(MAX_RETRY)) ? retry + 1'b1 : retry;
        end
    end

    assign oTD_RESET_N = state != S_RESET;
    assign oI2C_REQ    = req;
    assign oI2C_DATA   = req ? TBL[idx] : '0;
    assign oVID_EN     = state == S_RUN;
    assign oSTD        = (oVID_EN && (pal_s ^ ntsc_s)) ? {pal_s, ntsc_s} : 2'b00;
    assign oBUSY       = !(state inside {S_RUN, S_FAIL});
    assign oFAIL       = state == S_FAIL;
    assign oRETRY      = retry;
endmodule

// File: tb/tb_td_init_ctrl.sv
// tb_td_init_ctrl: directed bench for td_init_ctrl with short timing parameters.
// Follows TD_RELOCK_EN to choose the expected S_RUN behaviour on lost stability.
module tb_td_init_ctrl;
    localparam int RH = 4, ST = 4, SF = 5, LT = 50, LC = 6, MR = 2;
    localparam logic [23:0] EXP [0:7] = '{
        24'h400F00, 24'h400004, 24'h401741, 24'h403102,
        24'h403DA2, 24'h403E6A, 24'h403FA0, 24'h400E00
    };

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stable = 1'b0, ntsc = 1'b0, pal = 1'b0, ack = 1'b0, ack_err = 1'b0;
    logic        td_rst_n, i2c_req, vid_en, busy, fail;
    logic [23:0] i2c_data;
    logic [1:0]  std;
    logic [3:0]  retry;
    int          vec = 0, err = 0;

    td_init_ctrl #(
        .RST_HOLD(RH), .SETTLE(ST), .STABLE_FILTER(SF),
        .LOCK_TIMEOUT(LT), .LOST_CYCLES(LC), .MAX_RETRY(MR)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iTD_Stable(stable), .iNTSC(ntsc), .iPAL(pal),
        .oTD_RESET_N(td_rst_n), .oI2C_REQ(i2c_req), .oI2C_DATA(i2c_data),
        .iI2C_ACK(ack), .iI2C_ERR(ack_err), .oVID_EN(vid_en), .oSTD(std),
        .oBUSY(busy), .oFAIL(fail), .oRETRY(retry)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0; ack = 1'b0; ack_err = 1'b0; stable = 1'b0; ntsc = 1'b0; pal = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic count_rst_low(output int n);
        n = 0;
        while (!td_rst_n && n < 100) begin
            n++;
            tick();
        end
    endtask

    // answers n writes, ACK 3 cycles after REQ; ERR on write err_at
    task automatic serve(input int n, input int err_at);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!i2c_req && w < 100) begin
                tick();
                w++;
            end
            vec++;
            if (i2c_req !== 1'b1) begin
                $display("FAIL wr%0d_req_wait: req=%b want 1", k, i2c_req);
                err++;
                return;
            end
            vec++;
            if (i2c_data !== EXP[k]) begin
                $display("FAIL wr%0d_data: got %h want %h", k, i2c_data, EXP[k]);
                err++;
            end
            tick(2);
            vec++;
            if (i2c_req !== 1'b1 || i2c_data !== EXP[k]) begin
                $display("FAIL wr%0d_hold: req=%b data=%h want 1 %h", k, i2c_req, i2c_data, EXP[k]);
                err++;
            end
            ack = 1'b1;
            ack_err = (k == err_at);
            tick();
            ack = 1'b0;
            ack_err = 1'b0;
            vec++;
            if (i2c_req !== 1'b0) begin
                $display("FAIL wr%0d_req_drop: req=%b want 0", k, i2c_req);
                err++;
            end
            if (k == err_at) return;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        vec++;
        if ({td_rst_n, i2c_req, i2c_data, vid_en, std, busy, fail, retry} !== {1'b0, 1'b0, 24'h0, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0}) begin
            $display("FAIL reset_values: got %b_%b_%h_%b_%b_%b_%b_%h want 0_0_000000_0_00_1_0_0",
                     td_rst_n, i2c_req, i2c_data, vid_en, std, busy, fail, retry);
            err++;
        end
    endtask

    task automatic test_init_lock;
        int n;
        do_reset();
        count_rst_low(n);
        vec++;
        if (n != RH) begin
            $display("FAIL rst_hold_len: got %0d want %0d", n, RH);
            err++;
        end
        serve(8, -1);
        stable = 1'b1;
        ntsc = 1'b1;
        tick(SF + 1);
        vec++;
        if (vid_en !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL lock_early: vid_en=%b busy=%b want 0 1", vid_en, busy);
            err++;
        end
        tick();
        vec++;
        if (vid_en !== 1'b1 || std !== 2'b01 || busy !== 1'b0) begin
            $display("FAIL lock_ntsc: vid_en=%b std=%b busy=%b want 1 01 0", vid_en, std, busy);
            err++;
        end
    endtask

    task automatic test_i2c_err;
        int n;
        do_reset();
        count_rst_low(n);
        serve(8, 2);
        vec++;
        if (retry !== 4'd1 || td_rst_n !== 1'b0) begin
            $display("FAIL err_retry: retry=%0d td_rst_n=%b want 1 0", retry, td_rst_n);
            err++;
        end
        count_rst_low(n);
        vec++;
        if (n != RH) begin
            $display("FAIL err_rst_hold: got %0d want %0d", n, RH);
            err++;
        end
        serve(1, -1);
    endtask

    task automatic test_retry_fail;
        int n;
        do_reset();
        count_rst_low(n);
        for (int s = 0; s <= MR; s++) begin
            serve(8, -1);
            tick(LT - 1);
            vec++;
            if (td_rst_n !== 1'b1 || fail !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL seq%0d_pre_timeout: td_rst_n=%b fail=%b busy=%b want 1 0 1", s, td_rst_n, fail, busy);
                err++;
            end
            tick();
            if (s < MR) begin
                vec++;
                if (td_rst_n !== 1'b0 || retry !== 4'(s + 1)) begin
                    $display("FAIL seq%0d_timeout: td_rst_n=%b retry=%0d want 0 %0d", s, td_rst_n, retry, s + 1);
                    err++;
                end
            end
        end
        vec++;
        if ({fail, retry, vid_en, busy, td_rst_n, i2c_req} !== {1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL fail_state: fail=%b retry=%0d vid=%b busy=%b rst_n=%b req=%b want 1 2 0 0 1 0",
                     fail, retry, vid_en, busy, td_rst_n, i2c_req);
            err++;
        end
        stable = 1'b1;
        tick(20);
        vec++;
        if (fail !== 1'b1 || vid_en !== 1'b0 || i2c_req !== 1'b0) begin
            $display("FAIL fail_sticky: fail=%b vid=%b req=%b want 1 0 0", fail, vid_en, i2c_req);
            err++;
        end
    endtask

    task automatic test_filter_toggle;
        int  n;
        logic locked = 1'b0;
        do_reset();
        count_rst_low(n);
        serve(8, -1);
        for (int i = 0; i < LT - 1; i++) begin
            stable = ((i / (SF - 1)) % 2) == 0;
            tick();
            locked |= vid_en;
        end
        vec++;
        if (locked !== 1'b0 || td_rst_n !== 1'b1) begin
            $display("FAIL toggle_no_lock: locked=%b td_rst_n=%b want 0 1", locked, td_rst_n);
            err++;
        end
        tick();
        vec++;
        if (td_rst_n !== 1'b0 || retry !== 4'd1) begin
            $display("FAIL toggle_timeout: td_rst_n=%b retry=%0d want 0 1", td_rst_n, retry);
            err++;
        end
    endtask

    task automatic test_run_relock;
        int  n;
        logic dropped = 1'b0;
        logic traffic = 1'b0;
        do_reset();
        count_rst_low(n);
        serve(8, -1);
        stable = 1'b1;
        pal = 1'b1;
        tick(SF + 2);
        vec++;
        if (vid_en !== 1'b1 || std !== 2'b10) begin
            $display("FAIL lock_pal: vid_en=%b std=%b want 1 10", vid_en, std);
            err++;
        end
        pal = 1'b0; ntsc = 1'b1;
        tick(2);
        vec++;
        if (std !== 2'b01) begin
            $display("FAIL std_track_ntsc: got %b want 01", std);
            err++;
        end
        pal = 1'b1;
        tick(2);
        vec++;
        if (std !== 2'b00) begin
            $display("FAIL std_track_both: got %b want 00", std);
            err++;
        end
        ntsc = 1'b0;
        tick(2);
        stable = 1'b0;
        tick(LC - 1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            dropped |= !vid_en;
        end
        vec++;
        if (dropped !== 1'b0) begin
            $display("FAIL short_loss: vid_en dropped=%b want 0", dropped);
            err++;
        end
        stable = 1'b0;
        tick(LC + 1);
        vec++;
        if (vid_en !== 1'b1) begin
            $display("FAIL loss_early: vid_en=%b want 1", vid_en);
            err++;
        end
        tick();
`ifdef TD_RELOCK_EN
        vec++;
        if (vid_en !== 1'b0 || std !== 2'b00 || busy !== 1'b1 || retry !== 4'd0) begin
            $display("FAIL relock_drop: vid=%b std=%b busy=%b retry=%0d want 0 00 1 0", vid_en, std, busy, retry);
            err++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            traffic |= i2c_req | !td_rst_n;
        end
        vec++;
        if (traffic !== 1'b0) begin
            $display("FAIL relock_no_i2c: traffic=%b want 0", traffic);
            err++;
        end
        stable = 1'b1;
        tick(SF + 2);
        vec++;
        if (vid_en !== 1'b1 || std !== 2'b10) begin
            $display("FAIL relock_again: vid=%b std=%b want 1 10", vid_en, std);
            err++;
        end
`else
        vec++;
        if (vid_en !== 1'b1 || std !== 2'b10 || busy !== 1'b0) begin
            $display("FAIL run_terminal: vid=%b std=%b busy=%b want 1 10 0", vid_en, std, busy);
            err++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            traffic |= !vid_en | i2c_req;
        end
        vec++;
        if (traffic !== 1'b0) begin
            $display("FAIL run_hold: changed=%b want 0", traffic);
            err++;
        end
`endif
    endtask

    task automatic test_async_reset;
        int n;
        int w = 0;
        do_reset();
        count_rst_low(n);
        serve(5, -1);
        while (!i2c_req && w < 100) begin
            tick();
            w++;
        end
        vec++;
        if (i2c_req !== 1'b1 || i2c_data !== EXP[5]) begin
            $display("FAIL idx5_req: req=%b data=%h want 1 %h", i2c_req, i2c_data, EXP[5]);
            err++;
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({td_rst_n, i2c_req, i2c_data, vid_en, std, busy, fail, retry} !== {1'b0, 1'b0, 24'h0, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0}) begin
            $display("FAIL async_reset: got %b_%b_%h_%b_%b_%b_%b_%h want 0_0_000000_0_00_1_0_0",
                     td_rst_n, i2c_req, i2c_data, vid_en, std, busy, fail, retry);
            err++;
        end
        tick();
        rst_n = 1'b1;
        count_rst_low(n);
        vec++;
        if (n != RH) begin
            $display("FAIL async_rst_hold: got %0d want %0d", n, RH);
            err++;
        end
        serve(1, -1);
    endtask

    initial begin
        test_reset();
        test_init_lock();
        test_i2c_err();
        test_retry_fail();
        test_filter_toggle();
        test_run_relock();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
